cube_runner: RTL

- Parametrised successor to the single-step cube top.
- Holds the cube state and buffers a queue of moves (FIFO, depth DEPTH).
- On start, drives an external move engine one move at a time over a req/ack handshake. After the last move, compares the state with a goal state.
- Keeps a LIFO history of applied moves so an undo run can replay their inverses in reverse order.

---
 rtl/cube_runner_pkg.sv | 26 ++
 rtl/cube_runner_move_fifo.sv | 52 +++++
 rtl/cube_runner.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cube_runner_pkg.sv
// Shared definitions for the cube runner: FSM encodings, move-code limits
// and move-code helpers used by the runner and its testbench.
package cube_runner_pkg;

  typedef enum logic [2:0] {
    RN_IDLE  = 3'd0,
    RN_FETCH = 3'd1,
    RN_ISSUE = 3'd2,
    RN_WAIT  = 3'd3,
    RN_DONE  = 3'd4
  } rn_state_t;

  localparam logic [3:0] MV_NOP = 4'd0;
  localparam logic [3:0] MV_MAX = 4'd12;

  // Codes are 1+2*face+dir, so flipping the low bit of (code-1) swaps cw/ccw.
  function automatic logic [3:0] inv_move(input logic [3:0] c);
    if (c == MV_NOP) return MV_NOP;
    return ((c - 4'd1) ^ 4'd1) + 4'd1;
  endfunction

  function automatic logic is_legal(input logic [3:0] c);
    return c <= MV_MAX;
  endfunction

endpackage

// File: rtl/cube_runner_move_fifo.sv
// DEPTH x 4-bit synchronous move FIFO with occupancy count and
// combinational head read.
module move_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [3:0]               wr_data,
  input  logic                     rd_en,
  output logic [3:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cube_runner.sv
// Cube runner: buffers moves, replays them through an external engine over
// req/ack, keeps a ring-stack history for undo runs, checks against GOAL.
module cube_runner
  import cube_runner_pkg::*;
#(
  parameter int                  STATE_W = 120,
  parameter int                  DEPTH   = 16,
  parameter logic [STATE_W-1:0]  GOAL    = {STATE_W{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    store,
  input  logic [STATE_W-1:0]      store_data,
  input  logic                    mv_valid,
  input  logic [3:0]              mv_code,
  output logic                    mv_ready,
  input  logic                    start,
  input  logic                    undo,
  output logic                    eng_req,
  output logic [3:0]              eng_step,
  output logic [STATE_W-1:0]      eng_state,
  input  logic                    eng_ack,
  input  logic [STATE_W-1:0]      eng_result,
  output logic                    busy,
  output logic                    done,
  output logic                    solved,
  output logic                    err,
  output logic [$clog2(DEPTH):0]  count,
  output logic [STATE_W-1:0]      q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] d);
    return (d == CW'(DEPTH)) ? d : d + CW'(1);
  endfunction

  rn_state_t     state;
  logic          undo_r;

  logic          push_acc;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [3:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  logic [3:0]    hist [DEPTH];
  logic [AW-1:0] hist_top;
  logic [CW-1:0] hist_depth;
  logic          hist_empty;
  logic          hist_push;
  logic          hist_pop;
  logic          hist_clr;
  logic [3:0]    hist_push_code;
  logic [3:0]    hist_head;

  logic          fetch_avail;
  logic [3:0]    fetch_code;

  assign mv_ready  = !fifo_full && (state == RN_IDLE);
  assign push_acc  = mv_valid && mv_ready;
  assign fifo_wr   = push_acc && is_legal(mv_code);
  assign fifo_rd   = (state == RN_FETCH) && !undo_r && !fifo_empty;
  assign busy      = (state != RN_IDLE);
  assign eng_state = q;

  assign hist_empty  = (hist_depth == '0);
  assign hist_head   = hist[hist_top - AW'(1)];
  assign fetch_avail = undo_r ? !hist_empty : !fifo_empty;
  assign fetch_code  = undo_r ? inv_move(hist_head) : fifo_head;

  // Forward runs record nops at fetch and real moves once the engine acks.
  assign hist_push = !undo_r &&
                     (((state == RN_FETCH) && fetch_avail && (fetch_code == MV_NOP)) ||
                      ((state == RN_WAIT) && eng_ack));
  assign hist_push_code = (state == RN_WAIT) ? eng_step : MV_NOP;
  assign hist_pop       = undo_r && (state == RN_FETCH) && !hist_empty;
  assign hist_clr       = store && (state == RN_IDLE);

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (mv_code),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (hist_push && !hist_clr) hist[hist_top] <= hist_push_code;
  end

  // Ring stack: when full, a push overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_top   <= '0;
      hist_depth <= '0;
    end else if (hist_clr) begin
      hist_top   <= '0;
      hist_depth <= '0;
    end else if (hist_push) begin
      hist_top   <= hist_top + AW'(1);
      hist_depth <= sat_inc(hist_depth);
    end else if (hist_pop) begin
      hist_top   <= hist_top - AW'(1);
      hist_depth <= hist_depth - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RN_IDLE;
      undo_r   <= 1'b0;
      eng_req  <= 1'b0;
      eng_step <= MV_NOP;
      done     <= 1'b0;
      solved   <= 1'b0;
      err      <= 1'b0;
      q        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        RN_IDLE: begin
          if (store) begin
            q      <= store_data;
            err    <= 1'b0;
            solved <= 1'b0;
          end else if (start) begin
            undo_r <= undo;
            solved <= 1'b0;
            state  <= RN_FETCH;
          end
          if (push_acc && !is_legal(mv_code)) err <= 1'b1;
        end
        RN_FETCH: begin
          if (!fetch_avail) begin
            solved <= (q == GOAL);
            done   <= 1'b1;
            state  <= RN_DONE;
          end else if (fetch_code != MV_NOP) begin
            eng_step <= fetch_code;
            eng_req  <= 1'b1;
            state    <= RN_ISSUE;
          end
        end
        RN_ISSUE: state <= RN_WAIT;
        RN_WAIT: begin
          if (eng_ack) begin
            q       <= eng_result;
            eng_req <= 1'b0;
            state   <= RN_FETCH;
          end
        end
        RN_DONE: state <= RN_IDLE;
        default: state <= RN_IDLE;
      endcase
    end
  end

endmodule
